// File: rtl/gbsha_ttfir_host.sv
`default_nettype none
// ============================================================================
// Module  : gbsha_ttfir_host
// Brief   : Host adapter that drives a 4-tap TinyTapeout FIR filter over an
//           8-bit pin interface. It issues reset/configuration ticks,
//           streams one sample at a time and reconstructs a 13-bit result.
//           In low-bit mode this takes a second (drain) tick.
// Revision: 1.0 - initial release
// ============================================================================
module gbsha_ttfir_host #(
   parameter int N_TAPS = 4,
   parameter int BW_IN  = 6,
   parameter int BW_OUT = 8,
   parameter int BW_SUM = 13
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    cfg_valid,
   output logic                    cfg_ready,
   input  logic                    cfg_lsb,
   input  logic [N_TAPS*BW_IN-1:0] cfg_coef,
   input  logic                    s_valid,
   output logic                    s_ready,
   input  logic [BW_IN-1:0]        s_data,
   output logic                    y_valid,
   input  logic                    y_ready,
   output logic [BW_SUM-1:0]       y_data,
   output logic [BW_OUT-1:0]       fir_io_in,
   input  logic [BW_OUT-1:0]       fir_io_out,
   output logic                    busy
);

   typedef enum logic [3:0] {
      IDLE  = 4'd0,
      RST   = 4'd1,
      CFG   = 4'd2,
      READY = 4'd3,
      S_L   = 4'd4,
      S_H   = 4'd5,
      S_CAP = 4'd6,
      D_H   = 4'd7,
      D_CAP = 4'd8,
      OUT   = 4'd9
   } state_t;

   state_t                    r_state;
   state_t                    w_state_nx;
   logic                      r_phase;     // 0 = L cycle, 1 = H cycle of a tick
   logic                      w_phase_nx;
   logic [2:0]                r_tick;      // tick index within RST / CFG
   logic [2:0]                w_tick_nx;
   logic                      r_lsb;
   logic [N_TAPS*BW_IN-1:0]   r_coef;
   logic [BW_OUT-1:0]         r_hi;
   logic [BW_SUM-1:0]         r_y;
   logic [BW_OUT-1:0]         r_fir;
   logic [BW_OUT-1:0]         w_fir_nx;
   logic [BW_IN-1:0]          w_cfg_byte;
   logic                      w_cfg_hs;

   assign cfg_ready = (r_state == IDLE) || (r_state == READY);
   assign s_ready   = (r_state == READY);
   assign y_valid   = (r_state == OUT);
   assign busy      = (r_state == RST) || (r_state == CFG);
   assign y_data    = r_y;
   assign fir_io_in = r_fir;
   assign w_cfg_hs  = cfg_valid && cfg_ready;

   // Next-state logic: tick sequencing for RST/CFG and the sample pipeline.
   always_comb begin
      w_state_nx = r_state;
      w_phase_nx = r_phase;
      w_tick_nx  = r_tick;
      case (r_state)
         IDLE: begin
            if (w_cfg_hs) begin
               w_state_nx = RST;
               w_phase_nx = 1'b0;
               w_tick_nx  = 3'd0;
            end
         end
         READY: begin
            // Configuration wins over a simultaneous sample.
            if (w_cfg_hs) begin
               w_state_nx = RST;
               w_phase_nx = 1'b0;
               w_tick_nx  = 3'd0;
            end else if (s_valid) begin
               w_state_nx = S_L;
            end
         end
         RST: begin
            if (!r_phase) begin
               w_phase_nx = 1'b1;
            end else begin
               w_phase_nx = 1'b0;
               if (r_tick == 3'd1) begin
                  w_state_nx = CFG;
                  w_tick_nx  = 3'd0;
               end else begin
                  w_tick_nx  = r_tick + 3'd1;
               end
            end
         end
         CFG: begin
            if (!r_phase) begin
               w_phase_nx = 1'b1;
            end else begin
               w_phase_nx = 1'b0;
               if (r_tick == 3'd4) begin
                  w_state_nx = READY;
                  w_tick_nx  = 3'd0;
               end else begin
                  w_tick_nx  = r_tick + 3'd1;
               end
            end
         end
         S_L:     w_state_nx = S_H;
         S_H:     w_state_nx = S_CAP;
         // S_CAP doubles as the L half of the drain tick in low-bit mode.
         S_CAP:   w_state_nx = r_lsb ? D_H : OUT;
         D_H:     w_state_nx = D_CAP;
         D_CAP:   w_state_nx = OUT;
         OUT: begin
            if (y_ready) w_state_nx = READY;
         end
         default: w_state_nx = IDLE;
      endcase
   end

   // Configuration byte order: mode byte first, then h3 down to h0.
   always_comb begin
      w_cfg_byte = '0;
      case (w_tick_nx)
         3'd0:    w_cfg_byte = {5'b0, r_lsb};
         3'd1:    w_cfg_byte = r_coef[23:18];
         3'd2:    w_cfg_byte = r_coef[17:12];
         3'd3:    w_cfg_byte = r_coef[11:6];
         3'd4:    w_cfg_byte = r_coef[5:0];
         default: w_cfg_byte = '0;
      endcase
   end

   // Pin value for the next cycle; registered so the filter clock is glitch-free.
   always_comb begin
      w_fir_nx = '0;
      case (w_state_nx)
         RST:     w_fir_nx = {6'b0, 1'b1, w_phase_nx};
         CFG:     w_fir_nx = {w_cfg_byte, 1'b0, w_phase_nx};
         S_L:     w_fir_nx = {s_data, 2'b00};
         S_H:     w_fir_nx = {r_fir[7:1], 1'b1};
         D_H:     w_fir_nx = {r_fir[7:1], 1'b1};
         default: w_fir_nx = '0;
      endcase
   end

   // State, pin and result registers; async reset drops the filter clock at once.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_phase <= 1'b0;
         r_tick  <= 3'd0;
         r_lsb   <= 1'b0;
         r_coef  <= '0;
         r_hi    <= '0;
         r_y     <= '0;
         r_fir   <= '0;
      end else begin
         r_state <= w_state_nx;
         r_phase <= w_phase_nx;
         r_tick  <= w_tick_nx;
         r_fir   <= w_fir_nx;
         if (w_cfg_hs) begin
            r_lsb  <= cfg_lsb;
            r_coef <= cfg_coef;
         end
         if (r_state == S_CAP) begin
            r_hi <= fir_io_out;
            if (!r_lsb) r_y <= {fir_io_out, 5'b0};
         end
         // Sum bits [4:3] are not returned by the filter and read as zero.
         if (r_state == D_CAP) r_y <= {r_hi, 2'b00, fir_io_out[7:5]};
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_gbsha_ttfir_host.sv
`default_nettype none
// ============================================================================
// Module  : tb_gbsha_ttfir_host
// Brief   : Self-checking bench for gbsha_ttfir_host with a behavioural
//           model of the 4-tap TinyTapeout FIR filter on the pin side.
// Revision: 1.0 - initial release
// ============================================================================
module tb_gbsha_ttfir_host;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cfg_valid = 1'b0;
   logic        cfg_lsb = 1'b0;
   logic [23:0] cfg_coef = '0;
   logic        s_valid = 1'b0;
   logic [5:0]  s_data = '0;
   logic        y_ready = 1'b0;
   logic        cfg_ready, s_ready, y_valid, busy;
   logic [12:0] y_data;
   logic [7:0]  fir_io_in;
   logic [7:0]  fir_io_out;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   gbsha_ttfir_host dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_lsb    (cfg_lsb),
      .cfg_coef   (cfg_coef),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_data     (s_data),
      .y_valid    (y_valid),
      .y_ready    (y_ready),
      .y_data     (y_data),
      .fir_io_in  (fir_io_in),
      .fir_io_out (fir_io_out),
      .busy       (busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- filter behavioural model (pin side) ----------------
   logic [7:0]  f_out = 8'h00;
   logic [12:0] f_sum = '0;
   int          f_cnt = 0;
   bit          f_lsb = 1'b0;
   bit          f_phase = 1'b0;
   int          f_h[4] = '{0, 0, 0, 0};
   int          f_x[4] = '{0, 0, 0, 0};
   int          f_edges = 0;
   logic [7:0]  f_log[$];

   assign fir_io_out = f_out;

   always @(posedge fir_io_in[0]) begin : filt
      int acc;
      f_edges++;
      f_log.push_back(fir_io_in);
      if (fir_io_in[1]) begin
         f_cnt = 0; f_phase = 1'b0; f_out = 8'h00;
         for (int k = 0; k < 4; k++) f_x[k] = 0;
      end else if (f_cnt < 5) begin
         if (f_cnt == 0) f_lsb = fir_io_in[2];
         else            f_h[4 - f_cnt] = $signed(fir_io_in[7:2]);
         f_cnt++;
      end else if (f_lsb && f_phase) begin
         f_out = {f_sum[2:0], 5'b0};
         f_phase = 1'b0;
      end else begin
         for (int k = 3; k > 0; k--) f_x[k] = f_x[k-1];
         f_x[0] = $signed(fir_io_in[7:2]);
         acc = 0;
         for (int k = 0; k < 4; k++) acc += f_h[k] * f_x[k];
         f_sum = acc[12:0];
         f_out = f_sum[12:5];
         f_phase = f_lsb;
      end
   end

   // ---------------- transaction-level reference model ----------------
   int          cyc = 0;
   int          t_cfg = -100;
   int          t_acc = 0;
   int          m_lat = 0;
   bit          m_cfgd = 1'b0;
   bit          m_infl = 1'b0;
   bit          m_lsb = 1'b0;
   int          m_h[4] = '{0, 0, 0, 0};
   int          m_x[4] = '{0, 0, 0, 0};
   logic [12:0] m_exp = '0;

   function automatic bit e_busy();
      return (cyc >= t_cfg + 1) && (cyc <= t_cfg + 14);
   endfunction
   function automatic bit e_yv();
      return m_infl && (cyc >= t_acc + m_lat);
   endfunction
   function automatic bit e_cfgr();
      return !e_busy() && !m_infl;
   endfunction
   function automatic bit e_sr();
      return m_cfgd && (cyc >= t_cfg + 15) && !m_infl;
   endfunction

   always @(posedge clk) begin : model
      int acc;
      logic [12:0] s;
      if (!reset_n) begin
         m_cfgd = 1'b0; m_infl = 1'b0; t_cfg = -100;
      end else if (e_yv()) begin
         if (y_ready) m_infl = 1'b0;
      end else if (e_cfgr() && cfg_valid) begin
         t_cfg = cyc; m_cfgd = 1'b1; m_lsb = cfg_lsb;
         for (int k = 0; k < 4; k++) begin
            m_h[k] = $signed(cfg_coef[k*6 +: 6]);
            m_x[k] = 0;
         end
      end else if (e_sr() && s_valid) begin
         for (int k = 3; k > 0; k--) m_x[k] = m_x[k-1];
         m_x[0] = $signed(s_data);
         acc = 0;
         for (int k = 0; k < 4; k++) acc += m_h[k] * m_x[k];
         s = acc[12:0];
         m_exp = m_lsb ? {s[12:5], 2'b00, s[2:0]} : {s[12:5], 5'b0};
         m_infl = 1'b1; t_acc = cyc; m_lat = m_lsb ? 6 : 4;
      end
      cyc++;
   end

   // Compare DUT outputs against the model every cycle on the falling edge.
   always @(negedge clk) begin
      if (!reset_n) begin
         chk("rst_cfg_ready", cfg_ready, 1);
         chk("rst_s_ready", s_ready, 0);
         chk("rst_y_valid", y_valid, 0);
         chk("rst_busy", busy, 0);
         chk("rst_y_data", y_data, 0);
         chk("rst_fir_io_in", fir_io_in, 0);
      end else begin
         chk("busy", busy, e_busy());
         chk("cfg_ready", cfg_ready, e_cfgr());
         chk("s_ready", s_ready, e_sr());
         chk("y_valid", y_valid, e_yv());
         if (e_yv()) chk("y_data", y_data, m_exp);
         if (!e_busy() && !m_infl) chk("fir_clk_idle", fir_io_in[0], 0);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic do_cfg(input bit lsb, input logic [23:0] coef);
      int n = 0;
      @(negedge clk);
      cfg_valid = 1'b1; cfg_lsb = lsb; cfg_coef = coef;
      while (!cfg_ready && n < 50) begin @(negedge clk); n++; end
      if (!cfg_ready) chk("cfg_hs_timeout", cfg_ready, 1);
      @(posedge clk); #1 cfg_valid = 1'b0;
   endtask

   task automatic wait_ready(output int n, output int nb);
      n = 0; nb = 0;
      do begin
         @(negedge clk); n++;
         if (busy) nb++;
      end while (!s_ready && n < 40);
      if (!s_ready) chk("ready_timeout", s_ready, 1);
   endtask

   task automatic send(input logic [5:0] x);
      int n = 0;
      @(negedge clk);
      s_valid = 1'b1; s_data = x;
      while (!s_ready && n < 60) begin @(negedge clk); n++; end
      if (!s_ready) chk("s_hs_timeout", s_ready, 1);
      @(posedge clk); #1 s_valid = 1'b0;
   endtask

   task automatic wait_y(output int n);
      n = 0;
      do begin @(negedge clk); n++; end while (!y_valid && n < 40);
      if (!y_valid) chk("y_valid_timeout", y_valid, 1);
   endtask

   task automatic consume();
      y_ready = 1'b1;
      @(posedge clk); #1 y_ready = 1'b0;
   endtask

   task automatic consume_random();
      int n = 0;
      bit done = 1'b0;
      while (!done && n < 100) begin
         @(negedge clk);
         y_ready = $urandom_range(0, 1) == 1;
         if (y_valid && y_ready) done = 1'b1;
         n++;
      end
      if (!done) chk("consume_timeout", y_valid, 1);
      @(posedge clk); #1 y_ready = 1'b0;
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1);
   end

   initial begin : stim
      int n, nb, e0;
      logic [12:0] yv;
      logic [7:0] exp_log[7];
      logic [31:0] r1, r2;
      exp_log = '{8'h03, 8'h03, 8'h01, 8'h01, 8'h01, 8'h01, 8'h05};

      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // Tick sequence and busy window of a first configuration.
      f_log.delete();
      do_cfg(1'b0, 24'h000001);
      wait_ready(n, nb);
      chk("t31_ready_lat", n, 15);
      chk("t31_busy_cycles", nb, 14);
      chk("t31_tick_count", f_log.size(), 7);
      for (int i = 0; i < 7; i++)
         if (i < f_log.size()) chk($sformatf("t31_tick%0d", i), f_log[i], exp_log[i]);

      // h0 = -32, sample -32, high-byte mode.
      do_cfg(1'b0, 24'h000020);
      wait_ready(n, nb);
      send(6'h20);
      wait_y(n);
      chk("t32_latency", n, 4);
      chk("t32_y", y_data, 13'd1024);
      consume();

      // Low-bit mode, h0 = 1: samples 7 and -1.
      do_cfg(1'b1, 24'h000001);
      wait_ready(n, nb);
      send(6'd7);
      wait_y(n);
      chk("t33_latency", n, 6);
      chk("t33_y_pos", y_data, 13'd7);
      consume();
      send(6'h3F);
      wait_y(n);
      chk("t33_y_neg", y_data, 13'h1FE7);
      consume();

      // Back-pressure: result held, no filter clock edges.
      do_cfg(1'b0, 24'h000003);
      wait_ready(n, nb);
      send(6'd20);
      wait_y(n);
      yv = y_data;
      e0 = f_edges;
      chk("t34_y", yv, 13'd32);
      repeat (10) begin
         @(negedge clk);
         chk("t34_hold_valid", y_valid, 1);
         chk("t34_hold_data", y_data, yv);
      end
      chk("t34_no_edges", f_edges, e0);
      consume();
      @(negedge clk);
      chk("t34_ready_after", s_ready, 1);

      // Simultaneous cfg and sample in READY: cfg wins.
      cfg_valid = 1'b1; cfg_lsb = 1'b0; cfg_coef = 24'h00001F;
      s_valid = 1'b1; s_data = 6'd31;
      @(posedge clk); #1 cfg_valid = 1'b0;
      @(negedge clk);
      chk("t35_busy", busy, 1);
      chk("t35_rst_tick", fir_io_in, 8'h02);
      n = 0;
      while (!s_ready && n < 40) begin @(negedge clk); n++; end
      chk("t35_pending_ready", s_ready, 1);
      @(posedge clk); #1 s_valid = 1'b0;
      wait_y(n);
      chk("t35_y", y_data, 13'd960);
      consume();

      // Reset during the H cycle of a sample tick.
      send(6'd5);
      @(posedge clk);
      #1 chk("t36_in_sh", fir_io_in[0], 1);
      #1 reset_n = 1'b0;
      #1;
      chk("t36_fir_cleared", fir_io_in, 0);
      chk("t36_y_valid", y_valid, 0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("t36_s_ready_low", s_ready, 0);
         chk("t36_cfg_ready", cfg_ready, 1);
      end

      // Randomized configurations, samples and back-pressure.
      for (int c = 0; c < 6; c++) begin
         r1 = $urandom; r2 = $urandom;
         do_cfg(r1[0], r2[23:0]);
         wait_ready(n, nb);
         for (int s = 0; s < 12; s++) begin
            r1 = $urandom;
            repeat (r1[9:8]) @(negedge clk);
            send(r1[5:0]);
            consume_random();
         end
      end

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
